// File: rtl/piso_pkg.sv
// piso_pkg: shared types and sizing helper for the parallel-in serial-out shift register
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_t;
  function automatic int cnt_width(input int lanes);
    return lanes > 1 ? $clog2(lanes) : 1;
  endfunction
endpackage

// File: rtl/piso_beat_cnt.sv
// piso_beat_cnt: lane counter that flags the final lane of a word
module piso_beat_cnt
  import piso_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         incr,
  output logic [cnt_width(LANES)-1:0]  cnt,
  output logic                         at_last
);
  localparam int CNT_W = cnt_width(LANES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);
  // clear wins over incr so a new word always restarts at lane 0
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (incr) cnt <= cnt + 1'b1;
  end
  // last-lane flag straight from the count
  always_comb at_last = cnt == LAST;
endmodule

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: wide word in, LANES narrow beats out; PISO_MSB_FIRST_EN emits the highest lane first
module piso_shift_reg
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [LANES*DATA_WIDTH-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_last
);
  localparam int CNT_W = cnt_width(LANES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);
  piso_state_t state_r, state_nx;
  logic [LANES*DATA_WIDTH-1:0] hold_r;
  logic [CNT_W-1:0] cnt, idx;
  logic at_last, accept, beat, done;
  piso_beat_cnt #(.LANES(LANES)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept || done),
    .incr    (beat && !m_last),
    .cnt     (cnt),
    .at_last (at_last)
  );
  // state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else state_r <= state_nx;
  end
  // word holding register, loaded only on an accepted input word
  always_ff @(posedge clk) begin
    if (rst) hold_r <= '0;
    else if (accept) hold_r <= s_data;
  end
  // a reload on the last beat keeps SHIFT so words stream without a bubble
  always_comb state_nx = accept ? SHIFT : done ? IDLE : state_r;
  // handshakes and lane mux; s_ready is combinational from m_ready to allow back-to-back words
  always_comb begin
    m_valid = state_r == SHIFT;
    m_last  = m_valid && at_last;
    beat    = m_valid && m_ready;
    done    = beat && m_last;
    s_ready = state_r == IDLE || done;
    accept  = s_valid && s_ready;
`ifdef PISO_MSB_FIRST_EN
    idx     = LAST - cnt;
`else
    idx     = cnt;
`endif
    m_data  = hold_r[idx*DATA_WIDTH +: DATA_WIDTH];
  end
endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: directed and random stimulus checked against a beat-queue reference model
module tb_piso_shift_reg;
  localparam int DW = 16;
  localparam int LN = 4;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  logic clk = 0, rst = 1, s_valid = 0, s_ready, m_valid, m_ready = 1, m_last;
  logic [LN*DW-1:0] s_data = '0;
  logic [DW-1:0] m_data;
  beat_t q[$];
  int checks = 0, errors = 0;
  localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] W2 = 64'hDDDD_CCCC_BBBB_AAAA;

  piso_shift_reg #(.DATA_WIDTH(DW), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // queue the word's lanes in emission order; the final one carries last
  task automatic push_word(input logic [LN*DW-1:0] w);
    for (int i = 0; i < LN; i++) begin
      beat_t b;
`ifdef PISO_MSB_FIRST_EN
      b.data = w[(LN-1-i)*DW +: DW];
`else
      b.data = w[i*DW +: DW];
`endif
      b.last = i == LN - 1;
      q.push_back(b);
    end
  endtask

  // one cycle: drive at negedge, check just after, then advance the model for the coming edge
  task automatic step(input logic r, input logic sv, input logic [LN*DW-1:0] d, input logic mr);
    logic ev, er;
    @(negedge clk);
    rst = r; s_valid = sv; s_data = d; m_ready = mr;
    #1;
    ev = q.size() > 0;
    er = q.size() == 0 || (q.size() == 1 && mr);
    chk("m_valid", 64'(m_valid), 64'(ev));
    chk("s_ready", 64'(s_ready), 64'(er));
    if (ev) begin
      chk("m_data", 64'(m_data), 64'(q[0].data));
      chk("m_last", 64'(m_last), 64'(q[0].last));
    end else chk("m_last_idle", 64'(m_last), 64'(0));
    if (r) q.delete();
    else begin
      if (ev && mr) void'(q.pop_front());
      if (sv && er) push_word(d);
    end
  endtask

  initial begin
    step(1, 0, '0, 1);
    step(1, 0, '0, 1);
    chk("rst_m_data", 64'(m_data), 64'(0));
    step(0, 0, '0, 1);
    // single word, continuous ready
    step(0, 1, W1, 1);
    repeat (5) step(0, 0, W2, 1);
    // backpressure while lane 1 is shown
    step(0, 1, W1, 1);
    step(0, 0, '0, 1);
    repeat (3) step(0, 1, W2, 0);
    repeat (5) step(0, 0, '0, 1);
    // back-to-back words with s_valid held
    step(0, 1, W1, 1);
    repeat (4) step(0, 1, W2, 1);
    repeat (5) step(0, 0, '0, 1);
    // reset mid-word, then restart at lane 0
    step(0, 1, W1, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(1, 0, '0, 1);
    step(0, 1, W2, 1);
    repeat (5) step(0, 0, '0, 1);
    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, 1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) != 0);
    repeat (6) step(0, 0, '0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
- Parallel-in, serial-out shift register with valid/ready handshakes on both sides.
- Accepts one wide word of LANES x DATA_WIDTH bits and emits it as LANES beats of DATA_WIDTH bits each.
- It is the counterpart of the serial-in delay-line shift register: it unpacks wide datapath results into narrow streams.
- Typical use: feeding a narrow output bus from a wide processing stage.

Parameters:
- DATA_WIDTH, 16: width of one output beat (lane).
- LANES, 8: lanes per input word; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- s_valid  input  1  input word valid.
- s_ready  output  1  block can accept an input word this cycle.
- s_data  input  LANES*DATA_WIDTH  input word; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- m_valid  output  1  output beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  DATA_WIDTH  current output lane.
- m_last  output  1  current beat is the final lane of the word.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- State: busy_r (IDLE=0 / SHIFT=1), cnt_r of width CNT_W, hold_r of LANES x DATA_WIDTH.
- Reset values: busy_r=0, cnt_r=0, hold_r=0. Resulting outputs: m_valid=0, m_last=0, m_data=0, s_ready=1.
- Input handshake: a word is accepted when s_valid && s_ready.
- s_ready = !busy_r || (m_valid && m_ready && m_last). This is combinational from m_ready by design and permits back-to-back words.
- On accept: hold_r<=s_data, cnt_r<=0, busy_r<=1.
- Latency: the first beat appears on m_data/m_valid in the cycle after accept.
- m_valid = busy_r; m_data = hold_r[cnt_r]; m_last = busy_r && (cnt_r == LANES-1).
- Output beat (m_valid && m_ready), not last: cnt_r<=cnt_r+1.
- Output beat, last, with a simultaneous new accept: reload hold_r, cnt_r<=0, busy_r stays 1. No bubble between words.
- Output beat, last, with no accept: busy_r<=0, cnt_r<=0.
- Backpressure: while m_valid && !m_ready, m_data, m_last and cnt_r hold stable and s_ready=0.
- Throughput: exactly LANES output cycles per word under continuous m_ready.
- LANES=1: every beat is last. The block acts as a one-deep registered skid-free stage with a full-rate path.
- Reset mid-word: remaining lanes are discarded. Next cycle: m_valid=0, s_ready=1.
- s_data is ignored when not accepted. Changes of s_data while s_ready=0 have no effect.
- cnt_r never exceeds LANES-1. There is no wrap beyond the last lane.

Optional Feature:
- Macro PISO_MSB_FIRST_EN.
- Defined: lanes are emitted highest index first, so m_data = hold_r[LANES-1-cnt_r]. m_last is still asserted on the LANES-th beat.
- Undefined: lane 0 is emitted first (default LSB-first).
- Handshake and timing are identical in both builds.

Decomposition:
- Package piso_pkg holds:
  - function cnt_width(lanes), returning max(1, $clog2(lanes));
  - typedef enum logic {IDLE, SHIFT} piso_state_t.
- One natural sub-module: piso_beat_cnt.
  - Inputs: clk, rst, clear, incr.
  - Outputs: cnt, at_last.
  - Parameter: LANES.
  - Keeps counter/last logic separate from the datapath mux.

Test Plan (DATA_WIDTH=16, LANES=4 unless noted):
- Single word 0x4444_3333_2222_1111, m_ready=1 -> beats 0x1111, 0x2222, 0x3333, 0x4444 on cycles T+1..T+4; m_last only on 0x4444; s_ready=0 on T+1..T+3; idle on T+5.
- Backpressure: m_ready low for 3 cycles while 0x2222 is shown -> m_data holds 0x2222 and m_valid holds 1 throughout; no beat is lost or repeated; s_ready stays 0.
- Back-to-back: second word 0xDDDD_CCCC_BBBB_AAAA with s_valid held high -> accepted in the 0x4444 cycle; 0xAAAA follows immediately; 8 beats in 8 cycles.
- Reset mid-word: assert rst after the 0x2222 beat -> next cycle m_valid=0, m_last=0, s_ready=1; a new word then restarts at lane 0.
- PISO_MSB_FIRST_EN defined, word 0x4444_3333_2222_1111 -> 0x4444, 0x3333, 0x2222, 0x1111; m_last on 0x1111.
- LANES=1, DATA_WIDTH=8, continuous valid/ready, inputs 0x01, 0x02, 0x03 -> outputs 0x01, 0x02, 0x03 one cycle later; m_last=1 on every beat; full rate.
